bfly_drain_buf: RTL and testbench
=================================

// Module: bfly_drain_buf
// PURPOSE
//  Output-side frame buffer for the FFT butterfly stage. It is the reader-side counterpart of the
//  input delay line. It collects DEPTH/16 blocks of butterfly results, 16 lanes per block. It then
//  drains the blocks, oldest first, to the next stage under a valid/ready handshake.
//  Single frame in flight: fill and drain never overlap.
// PARAMETERS
//  DATA_WIDTH  10   signed sample width per I/Q component (butterfly output width)
//  DEPTH       256  samples per frame; must be a multiple of 16 and >= 32 (NBLK = DEPTH/16 >= 2)
// PORTS
//  clk        in   1              clock, rising edge
//  rstn       in   1              asynchronous active-low reset
//  din_valid  in   1              butterfly block valid
//  din_i      in   DATA_WIDTH x16 [0:15] signed real lanes from butterfly
//  din_q      in   DATA_WIDTH x16 [0:15] signed imag lanes from butterfly
//  din_ready  out  1              buffer accepts a block this cycle
//  dout_valid out  1              block available to downstream
//  dout_ready in   1              downstream accepts block
//  dout_i     out  DATA_WIDTH x16 [0:15] signed real lanes, oldest stored block
//  dout_q     out  DATA_WIDTH x16 [0:15] signed imag lanes, oldest stored block
//  dout_last  out  1              high with dout_valid on the final block of a frame
//  busy       out  1              high in FILL or DRAIN
// BEHAVIOUR
//  - Reset (async, rstn=0):
//    - state=IDLE, count=0, all buffer entries cleared to 0.
//    - Outputs: din_ready=1, dout_valid=0, dout_last=0, busy=0, dout_i/dout_q all 0.
//  - Storage: buf_re/buf_im[0:DEPTH-1], handled as NBLK blocks of 16.
//    - dout_i/dout_q = buf[DEPTH-16 +: 16], driven directly from registers (no comb path from inputs).
//  - Counter: count is $clog2(NBLK+1) bits. It counts accepted blocks in FILL and handshaken blocks in DRAIN.
//  - States:
//    - IDLE: din_ready=1, busy=0. Accept (din_valid&din_ready): shift block n-1->n for n=NBLK-1..1;
//      load din into block 0; count=1; go to FILL.
//    - FILL: din_ready=1, busy=1. Each accept shifts and loads as in IDLE, then count++.
//      On the NBLK-th accept: count=0, go to DRAIN. The oldest block is now at the top.
//      No accept this cycle: hold everything.
//    - DRAIN: din_ready=0, dout_valid=1, busy=1, dout_last=(count==NBLK-1).
//      On dout_valid&dout_ready: shift block n-1->n for n=NBLK-1..1; write block 0 with 0; count++.
//      On the NBLK-th handshake: count=0, go to IDLE.
//  - Latency:
//    - dout_valid rises the cycle after the NBLK-th accepting edge.
//    - din_ready returns to 1 the cycle after the final drain handshake.
//  - Output stability: while dout_valid=1 and dout_ready=0, dout_i, dout_q and dout_last hold stable.
//  - Ignored inputs:
//    - din_valid while din_ready=0 (DRAIN) is ignored: no store, no count.
//    - dout_ready while dout_valid=0 is ignored.
//  - Data path: data is passed unmodified. No arithmetic, rounding or sign change.
//    Lane l of an input block appears on lane l of the output.
//  - Frame order: output block k of a frame is input block k (FIFO order), with no loss or duplication.
//  - Back-to-back frames: a new frame may start in the first IDLE cycle after a drain.
//  - Reset mid-operation: any state returns immediately to the reset values and a partial frame is discarded.
//    The next frame after reset behaves as the first frame.
// TESTING
//  T1 Reset: hold rstn=0 with random din -> din_ready=1, dout_valid=0, dout_last=0, busy=0, dout all 0.
//  T2 Full frame (DEPTH=256): 16 consecutive blocks with din_i[l]=16*b+l, din_q[l]=-(16*b+l), dout_ready=1
//     -> dout_valid rises 1 cycle after the 16th accept; blocks b=0..15 appear in order.
//     -> dout_last is high only on b=15; din_ready=1 one cycle later.
//  T3 Backpressure: dout_ready pattern 1,0,0,1,0,... during drain
//     -> each block is held stable until its handshake; exactly 16 distinct blocks, none lost or duplicated.
//  T4 Gapped input: din_valid asserted every 3rd cycle -> DRAIN is entered only after the 16th valid.
//     Then din_valid=1 with data 0x155 during DRAIN -> ignored; it never appears on dout.
//  T5 Reset mid-drain: after 5 blocks are drained, pulse rstn=0
//     -> dout_valid=0 and the buffer is zero at once.
//     A new 16-block frame then drains correctly, blocks 0..15.
//  T6 Extremes (DATA_WIDTH=10): lanes alternate -512 and +511 -> output matches bit-exactly, sign preserved.

Source files
------------

// File: rtl/bfly_drain_buf.sv
`default_nettype none
// ============================================================================
// Module   : bfly_drain_buf
// Purpose  : Output-side frame buffer for the FFT butterfly stage. Collects
//            NBLK = DEPTH/16 blocks of 16 complex lanes, then drains them
//            oldest-first to the next stage under a valid/ready handshake.
//            Only one frame is in flight: fill and drain never overlap.
// Ports    : clk        - clock, rising edge
//            rstn       - asynchronous active-low reset
//            din_valid  - butterfly block valid
//            din_i/q    - 16 signed real/imag input lanes
//            din_ready  - buffer accepts a block this cycle
//            dout_valid - block available to downstream
//            dout_ready - downstream accepts block
//            dout_i/q   - 16 signed real/imag lanes of the oldest block
//            dout_last  - final block of the frame (qualified by dout_valid)
//            busy       - high while filling or draining
// Params   : DATA_WIDTH - signed width per I/Q component
//            DEPTH      - samples per frame, multiple of 16 and >= 32
// Revision : 1.0 - initial release
// ============================================================================
module bfly_drain_buf #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 256
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         din_valid,
    input  logic signed [DATA_WIDTH-1:0] din_i [0:15],
    input  logic signed [DATA_WIDTH-1:0] din_q [0:15],
    output logic                         din_ready,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic signed [DATA_WIDTH-1:0] dout_i [0:15],
    output logic signed [DATA_WIDTH-1:0] dout_q [0:15],
    output logic                         dout_last,
    output logic                         busy
);

    localparam int NBLK = DEPTH / 16;
    localparam int CW   = $clog2(NBLK + 1);

    localparam logic [CW-1:0] c_ZERO = '0;
    localparam logic [CW-1:0] c_ONE  = CW'(1);
    localparam logic [CW-1:0] c_LAST = CW'(NBLK - 1);
    localparam logic [CW-1:0] c_PRE  = CW'(NBLK - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                        r_state;
    logic [CW-1:0]                 r_count;
    logic                          r_din_ready;
    logic                          r_dout_valid;
    logic                          r_dout_last;
    logic                          r_busy;

    // Block b occupies entries [16*b +: 16]; block NBLK-1 is the oldest.
    logic signed [DATA_WIDTH-1:0]  r_buf_re [0:DEPTH-1];
    logic signed [DATA_WIDTH-1:0]  r_buf_im [0:DEPTH-1];

    logic                          w_accept;
    logic                          w_handshake;

    // Both strobes depend only on registered flags plus the request inputs,
    // so they can never both be true (ready and valid are exclusive).
    assign w_accept    = din_valid  & r_din_ready;
    assign w_handshake = dout_ready & r_dout_valid;

    // ------------------------------------------------------------------
    // Control FSM: all handshake/status outputs are registered and are
    // updated together with the state so they reflect the new state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_count      <= c_ZERO;
            r_din_ready  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count <= c_ONE;
                        r_state <= S_FILL;
                        r_busy  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        if (r_count == c_LAST) begin
                            r_count      <= c_ZERO;
                            r_state      <= S_DRAIN;
                            r_din_ready  <= 1'b0;
                            r_dout_valid <= 1'b1;
                            // NBLK >= 2, so the first drained block is never last
                            r_dout_last  <= 1'b0;
                        end else begin
                            r_count <= r_count + c_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_handshake) begin
                        if (r_count == c_LAST) begin
                            r_count      <= c_ZERO;
                            r_state      <= S_IDLE;
                            r_din_ready  <= 1'b1;
                            r_dout_valid <= 1'b0;
                            r_dout_last  <= 1'b0;
                            r_busy       <= 1'b0;
                        end else begin
                            r_count     <= r_count + c_ONE;
                            // Next block presented is the last one
                            r_dout_last <= (r_count == c_PRE);
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_count      <= c_ZERO;
                    r_din_ready  <= 1'b1;
                    r_dout_valid <= 1'b0;
                    r_dout_last  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Block shift register. Fill and drain both shift one block towards
    // the top; fill loads new data into block 0, drain back-fills zeros so
    // the buffer is clean when the frame has fully left.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_re[i] <= '0;
                r_buf_im[i] <= '0;
            end
        end else if (w_accept || w_handshake) begin
            for (int i = 16; i < DEPTH; i++) begin
                r_buf_re[i] <= r_buf_re[i-16];
                r_buf_im[i] <= r_buf_im[i-16];
            end
            for (int l = 0; l < 16; l++) begin
                r_buf_re[l] <= w_accept ? din_i[l] : '0;
                r_buf_im[l] <= w_accept ? din_q[l] : '0;
            end
        end
    end

    // Output lanes come straight from the top block of the register file.
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_out_lane
            assign dout_i[g] = r_buf_re[DEPTH-16+g];
            assign dout_q[g] = r_buf_im[DEPTH-16+g];
        end
    endgenerate

    assign din_ready  = r_din_ready;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bfly_drain_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfly_drain_buf
// Purpose  : Self-checking bench for bfly_drain_buf. Expected blocks are
//            pushed to a scoreboard queue as they are accepted and compared
//            every drain cycle against the DUT output until handshaken.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfly_drain_buf;

    localparam int DW    = 10;
    localparam int DEPTH = 256;
    localparam int NBLK  = DEPTH / 16;

    typedef struct packed {
        logic [15:0][DW-1:0] re;
        logic [15:0][DW-1:0] im;
        logic                last;
    } blk_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic din_valid = 1'b0;
    logic dout_ready = 1'b0;
    logic signed [DW-1:0] din_i [0:15];
    logic signed [DW-1:0] din_q [0:15];
    logic signed [DW-1:0] dout_i [0:15];
    logic signed [DW-1:0] dout_q [0:15];
    logic din_ready, dout_valid, dout_last, busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    blk_t sb[$];

    always #5 clk = ~clk;

    bfly_drain_buf #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_i      (din_i),
        .din_q      (din_q),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_last  (dout_last),
        .busy       (busy)
    );

    function automatic blk_t cur_out();
        blk_t o;
        for (int l = 0; l < 16; l++) begin
            o.re[l] = dout_i[l];
            o.im[l] = dout_q[l];
        end
        o.last = dout_last;
        return o;
    endfunction

    function automatic blk_t make_blk(input int mode, input int b);
        blk_t o;
        int   v;
        for (int l = 0; l < 16; l++) begin
            case (mode)
                0: begin
                    v = 16 * b + l;
                    o.re[l] = v[DW-1:0];
                    v = -v;
                    o.im[l] = v[DW-1:0];
                end
                1: begin
                    o.re[l] = DW'($urandom);
                    o.im[l] = DW'($urandom);
                end
                default: begin
                    o.re[l] = (l % 2 == 0) ? 10'h200 : 10'h1FF;
                    o.im[l] = (l % 2 == 0) ? 10'h1FF : 10'h200;
                end
            endcase
        end
        o.last = (b == NBLK - 1);
        return o;
    endfunction

    task automatic drive_block(input blk_t b);
        for (int l = 0; l < 16; l++) begin
            din_i[l] = b.re[l];
            din_q[l] = b.im[l];
        end
    endtask

    // Presents NBLK blocks, optionally with idle gaps between them.
    task automatic fill_frame(input int mode, input int gap);
        blk_t b;
        for (int k = 0; k < NBLK; k++) begin
            din_valid = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                n_tests++;
                if (dout_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_gap_valid blk %0d got %b exp 0", k, dout_valid);
                end
            end
            b = make_blk(mode, k);
            drive_block(b);
            din_valid = 1'b1;
            n_tests++;
            if (din_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready blk %0d got %b exp 1", k, din_ready);
            end
            @(negedge clk);
            sb.push_back(b);
            n_tests++;
            if (k < NBLK - 1) begin
                if (dout_valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill_state blk %0d got valid=%b busy=%b exp valid=0 busy=1",
                             k, dout_valid, busy);
                end
            end else if (dout_valid !== 1'b1 || din_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_entry got valid=%b ready=%b exp valid=1 ready=0",
                         dout_valid, din_ready);
            end
        end
        din_valid = 1'b0;
    endtask

    // pat: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random.
    task automatic drain(input int pat, input int stop_after, input bit junk);
        int   done = 0;
        int   cyc  = 0;
        bit   rdy;
        blk_t act;
        while (done < stop_after && cyc < 400) begin
            n_tests++;
            if (dout_valid !== 1'b1 || din_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_valid got valid=%b ready=%b exp valid=1 ready=0",
                         dout_valid, din_ready);
                break;
            end
            act = cur_out();
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL drain_extra got %h exp no block", act);
            end else if (act !== sb[0]) begin
                n_fail++;
                $display("FAIL drain_data blk %0d got %h exp %h", done, act, sb[0]);
            end
            case (pat)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            dout_ready = rdy;
            if (junk) begin
                din_valid = 1'b1;
                for (int l = 0; l < 16; l++) begin
                    din_i[l] = 10'h155;
                    din_q[l] = 10'h155;
                end
            end
            @(negedge clk);
            if (rdy) begin
                if (sb.size() != 0) void'(sb.pop_front());
                done++;
            end
            cyc++;
        end
        dout_ready = 1'b0;
        din_valid  = 1'b0;
        n_tests++;
        if (cyc >= 400) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d blocks exp %0d", done, stop_after);
        end
        if (stop_after == NBLK) begin
            n_tests++;
            if (din_ready !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
                n_fail++;
                $display("FAIL drain_exit got ready=%b valid=%b busy=%b left=%0d exp 1 0 0 0",
                         din_ready, dout_valid, busy, sb.size());
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        blk_t act;
        act = cur_out();
        n_tests++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout_last !== 1'b0 ||
            busy !== 1'b0 || act !== '0) begin
            n_fail++;
            $display("FAIL %s got ready=%b valid=%b last=%b busy=%b out=%h exp 1 0 0 0 zero",
                     tag, din_ready, dout_valid, dout_last, busy, act);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        din_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < 16; l++) begin
                din_i[l] = DW'($urandom);
                din_q[l] = DW'($urandom);
            end
            @(negedge clk);
            check_reset_outputs("reset");
        end
        din_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_full_frame();
        fill_frame(0, 0);
        drain(0, NBLK, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_frame(1, 0);
        drain(1, NBLK, 1'b0);
    endtask

    task automatic test_gapped_and_ignored();
        fill_frame(0, 2);
        drain(2, NBLK, 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        fill_frame(1, 0);
        drain(0, 5, 1'b0);
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset_mid_drain");
        @(negedge clk);
        rstn = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("reset_mid_drain_idle");
        fill_frame(0, 0);
        drain(0, NBLK, 1'b0);
    endtask

    task automatic test_extremes();
        fill_frame(2, 0);
        drain(1, NBLK, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_frame(1, 0);
        drain(0, NBLK, 1'b0);
        fill_frame(1, 0);
        drain(2, NBLK, 1'b0);
    endtask

    initial begin
        for (int l = 0; l < 16; l++) begin
            din_i[l] = '0;
            din_q[l] = '0;
        end
        test_reset();
        test_full_frame();
        test_backpressure();
        test_gapped_and_ignored();
        test_reset_mid_drain();
        test_extremes();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
